// File: rtl/mux_scan_checker_if.sv
// Bundles the mux stimulus/response wires, the run handshake and the result bus of mux_scan_checker.
// The checker connects through the master modport. The environment or testbench connects through the slave modport.
interface mux_scan_checker_if #(
  parameter int CNT_W = 7
);
  logic             start;
  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             s0;
  logic             s1;
  logic             w1;
  logic             w2;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] mismatch_count;
  logic             fail_flag;
  logic [5:0]       first_fail_vec;

  modport master (
    input  start, w1, w2,
    output a, b, c, d, s0, s1, busy, done, mismatch_count, fail_flag, first_fail_vec
  );

  modport slave (
    output start, w1, w2,
    input  a, b, c, d, s0, s1, busy, done, mismatch_count, fail_flag, first_fail_vec
  );
endinterface

// File: rtl/mux_scan_checker.sv
// Walks all 64 data/select vectors into two 4:1 muxes and checks both outputs against the selected bit.
// Optional macro MUX_XCHECK_EN: a strict 4-state compare in which X/Z on w1/w2 counts as a mismatch.
module mux_scan_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_checker_if.master   bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [5:0]       vec, vec_nxt;
  logic [SW-1:0]    settle_cnt, settle_nxt;
  logic [CNT_W-1:0] mismatch_count, count_nxt;
  logic             fail_flag, fail_nxt;
  logic [5:0]       first_fail_vec, first_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic             expected;
  logic             mismatch;

  always_comb begin
    expected = 1'b0;
    case (vec[5:4])
      2'd0:    expected = vec[0];
      2'd1:    expected = vec[1];
      2'd2:    expected = vec[2];
      default: expected = vec[3];
    endcase
  end

  // Without the strict compare, an unknown mux output leaves the condition unknown, and that counts as a pass.
  always_comb begin
`ifdef MUX_XCHECK_EN
    mismatch = (bus.w1 !== expected) || (bus.w2 !== expected);
`else
    mismatch = 1'b0;
    if ((bus.w1 != expected) || (bus.w2 != expected)) begin
      mismatch = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt  = state;
    vec_nxt    = vec;
    settle_nxt = settle_cnt;
    count_nxt  = mismatch_count;
    fail_nxt   = fail_flag;
    first_nxt  = first_fail_vec;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          vec_nxt    = '0;
          settle_nxt = SETTLE_LOAD;
          count_nxt  = '0;
          fail_nxt   = 1'b0;
          first_nxt  = '0;
          busy_nxt   = 1'b1;
          state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt != '0) begin
          settle_nxt = settle_cnt - 1'b1;
        end else begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          if (mismatch_count != '1) begin
            count_nxt = mismatch_count + 1'b1;
          end
          if (!fail_flag) begin
            fail_nxt  = 1'b1;
            first_nxt = vec;
          end
        end
        // The last vector stays on the mux inputs until the next run starts.
        if (vec == 6'd63) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          vec_nxt    = vec + 1'b1;
          settle_nxt = SETTLE_LOAD;
          state_nxt  = SETTLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      settle_cnt     <= '0;
      mismatch_count <= '0;
      fail_flag      <= 1'b0;
      first_fail_vec <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      vec            <= vec_nxt;
      settle_cnt     <= settle_nxt;
      mismatch_count <= count_nxt;
      fail_flag      <= fail_nxt;
      first_fail_vec <= first_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
    end
  end

  assign bus.a              = vec[0];
  assign bus.b              = vec[1];
  assign bus.c              = vec[2];
  assign bus.d              = vec[3];
  assign bus.s0             = vec[4];
  assign bus.s1             = vec[5];
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.mismatch_count = mismatch_count;
  assign bus.fail_flag      = fail_flag;
  assign bus.first_fail_vec = first_fail_vec;

endmodule
